// File: rtl/epvl_xmtr.sv
// epvl_xmtr: backplane packet transmitter with length cap and inter-packet gap.
// Define EPVL_TX_STATS_EN to build the packet/word statistics counters.
module epvl_xmtr #(
    parameter int DATA_W     = 32,
    parameter int MAX_WORDS  = 256,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              bhold,
    output logic              bpvl,
    output logic              bdvl,
    output logic              bepvl,
    output logic [DATA_W-1:0] bdata,
    output logic              err_trunc,
    output logic [31:0]       pkt_count,
    output logic [31:0]       word_count
);
    localparam int LEN_W = $clog2(MAX_WORDS + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam bit HAS_GAP = (GAP_CYCLES > 0);
    localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_WORDS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST =
        GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DROP,
        GAP
    } state_t;

    state_t state, state_nx;
    state_t after_end;

    logic [LEN_W-1:0]  len, len_nx;
    logic [GAP_W-1:0]  gcnt, gcnt_nx;
    logic              bpvl_nx, bdvl_nx, bepvl_nx, err_nx;
    logic [DATA_W-1:0] bdata_nx;
    logic              accept, at_max, end_word;

    assign in_ready = ((state == IDLE) || (state == SEND) || (state == DROP))
                      && !bhold && !reset;
    assign accept    = in_valid && in_ready;
    assign at_max    = (len == LEN_LAST);
    assign end_word  = in_last || at_max;
    assign after_end = HAS_GAP ? GAP : IDLE;

    always_comb begin
        state_nx = state;
        len_nx   = len;
        gcnt_nx  = gcnt;
        bpvl_nx  = 1'b1;
        bdvl_nx  = 1'b1;
        bepvl_nx = 1'b0;
        err_nx   = 1'b0;
        bdata_nx = bdata;
        unique case (state)
            IDLE, SEND: begin
                if (accept) begin
                    bpvl_nx  = 1'b0;
                    bdvl_nx  = 1'b0;
                    bdata_nx = in_data;
                    if (end_word) begin
                        // Hitting the cap without in_last still closes the packet.
                        bepvl_nx = 1'b1;
                        err_nx   = !in_last;
                        len_nx   = '0;
                        gcnt_nx  = '0;
                        state_nx = in_last ? after_end : DROP;
                    end else begin
                        len_nx   = len + LEN_W'(1);
                        state_nx = SEND;
                    end
                end else if (state == SEND) begin
                    bpvl_nx = 1'b0;
                end
            end
            DROP: begin
                if (accept && in_last) begin
                    gcnt_nx  = '0;
                    state_nx = after_end;
                end
            end
            GAP: begin
                if (gcnt == GAP_LAST) begin
                    state_nx = IDLE;
                end else begin
                    gcnt_nx = gcnt + GAP_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            len       <= '0;
            gcnt      <= '0;
            bpvl      <= 1'b1;
            bdvl      <= 1'b1;
            bepvl     <= 1'b0;
            err_trunc <= 1'b0;
            bdata     <= '0;
        end else begin
            state     <= state_nx;
            len       <= len_nx;
            gcnt      <= gcnt_nx;
            bpvl      <= bpvl_nx;
            bdvl      <= bdvl_nx;
            bepvl     <= bepvl_nx;
            err_trunc <= err_nx;
            bdata     <= bdata_nx;
        end
    end

`ifdef EPVL_TX_STATS_EN
    logic [31:0] pkt_q, word_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_q  <= '0;
            word_q <= '0;
        end else begin
            if (bepvl) begin
                pkt_q <= pkt_q + 32'd1;
            end
            if (!bdvl) begin
                word_q <= word_q + 32'd1;
            end
        end
    end

    assign pkt_count  = pkt_q;
    assign word_count = word_q;
`else
    assign pkt_count  = '0;
    assign word_count = '0;
`endif

endmodule
